// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall FSM, branch flush/recover,
// load-use (or full decode-hazard) stall and operand forwarding.
// Build option: define HAZ_FWD_EN to enable forwarding and the narrow
// load-use stall; without it, forwards stay 00 and any decode read of a
// pending E/M destination stalls.
//
// state    | meaning
// RUN      | normal flow; starts memory waits, branch flushes, hazard stalls
// MEMWAIT  | data memory busy; whole pipe held until ack or timeout
// RECOVER  | one cycle after a taken branch; execute bubble only
module pipe_hazard_ctrl #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_RA1D,
  input  logic [3:0] i_RA2D,
  input  logic [3:0] i_RA1E,
  input  logic [3:0] i_RA2E,
  input  logic [3:0] i_WA3E,
  input  logic       i_RegWriteE,
  input  logic       i_MemtoRegE,
  input  logic [3:0] i_WA3M,
  input  logic       i_RegWriteM,
  input  logic       i_MemtoRegM,
  input  logic       i_MemWriteM,
  input  logic       i_PCSrcM,
  input  logic [3:0] i_WA3W,
  input  logic       i_RegWriteW,
  input  logic       i_mem_ack,
  output logic       o_StallF,
  output logic       o_StallD,
  output logic       o_StallE,
  output logic       o_StallM,
  output logic       o_FlushD,
  output logic       o_FlushE,
  output logic [1:0] o_ForwardAE,
  output logic [1:0] o_ForwardBE,
  output logic       o_mem_req,
  output logic [1:0] o_state,
  output logic       o_timeout
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_MEMWAIT = 2'b01,
    ST_RECOVER = 2'b10,
    ST_BAD     = 2'b11
  } state_t;

  // Last counter value before a wait is declared timed out.
  localparam logic [7:0] LP_CNT_LAST = 8'(WAIT_MAX - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_timeout, w_timeout_set;
  logic       w_mem_access, w_dec_hazard;
  logic       w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_flush_d, w_flush_e;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_mem_access = i_MemtoRegM | i_MemWriteM;

`ifdef HAZ_FWD_EN
  // Forward select per operand; memory stage has the newer value so it wins.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (i_RegWriteM && (i_WA3M == i_RA1E))      w_fwd_a = 2'b10;
    else if (i_RegWriteW && (i_WA3W == i_RA1E)) w_fwd_a = 2'b01;
    if (i_RegWriteM && (i_WA3M == i_RA2E))      w_fwd_b = 2'b10;
    else if (i_RegWriteW && (i_WA3W == i_RA2E)) w_fwd_b = 2'b01;
  end

  // Only a load in E cannot be covered by forwarding.
  assign w_dec_hazard = i_MemtoRegE & i_RegWriteE &
                        ((i_WA3E == i_RA1D) | (i_WA3E == i_RA2D));
`else
  assign w_fwd_a = 2'b00;
  assign w_fwd_b = 2'b00;

  // No bypass network: any in-flight writer of a decode source must drain.
  assign w_dec_hazard = (i_RegWriteE & ((i_WA3E == i_RA1D) | (i_WA3E == i_RA2D))) |
                        (i_RegWriteM & ((i_WA3M == i_RA1D) | (i_WA3M == i_RA2D)));

  logic w_unused_nofwd;
  assign w_unused_nofwd = ^{i_RA1E, i_RA2E, i_WA3W, i_RegWriteW, i_MemtoRegE};
`endif

  // Next-state, wait counter and hazard decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = 8'd0;
    w_timeout_set = 1'b0;
    w_stall_f     = 1'b0;
    w_stall_d     = 1'b0;
    w_stall_e     = 1'b0;
    w_stall_m     = 1'b0;
    w_flush_d     = 1'b0;
    w_flush_e     = 1'b0;
    o_mem_req     = 1'b0;
    case (r_state)
      ST_RUN: begin
        o_mem_req = w_mem_access;
        if (w_mem_access && !i_mem_ack) begin
          {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'hF;
          w_state_nxt = ST_MEMWAIT;
        end else if (i_PCSrcM) begin
          w_flush_d   = 1'b1;
          w_flush_e   = 1'b1;
          w_state_nxt = ST_RECOVER;
        end else if (w_dec_hazard) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_flush_e = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        o_mem_req = w_mem_access;
        if (i_mem_ack) begin
          // A branch that waited behind the access is taken now.
          if (i_PCSrcM) begin
            w_flush_d   = 1'b1;
            w_flush_e   = 1'b1;
            w_state_nxt = ST_RECOVER;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'hF;
          if (r_cnt == LP_CNT_LAST) begin
            w_timeout_set = 1'b1;
            w_state_nxt   = ST_RUN;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      ST_RECOVER: begin
        w_flush_e   = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Reset silences every stall/flush/forward at once, not just next cycle.
  always_comb begin
    o_StallF    = w_stall_f & ~rst;
    o_StallD    = w_stall_d & ~rst;
    o_StallE    = w_stall_e & ~rst;
    o_StallM    = w_stall_m & ~rst;
    o_FlushD    = w_flush_d & ~rst;
    o_FlushE    = w_flush_e & ~rst;
    o_ForwardAE = rst ? 2'b00 : w_fwd_a;
    o_ForwardBE = rst ? 2'b00 : w_fwd_b;
  end

  // State, wait counter and sticky timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= r_timeout | w_timeout_set;
    end
  end

  assign o_state   = r_state;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (honours HAZ_FWD_EN if defined).
module tb_pipe_hazard_ctrl;
  localparam int WMAX = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, MemWriteM, PCSrcM;
  logic       RegWriteW, mem_ack;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, mem_req, timeout;
  logic [1:0] FwdA, FwdB, state;
  logic [13:0] outv, exp;

  int n_checks = 0;
  int n_err    = 0;

  // Reference: mode 0 run, 1 waiting on memory, 2 post-branch bubble.
  int m_st  = 0;
  int m_cnt = 0;
  bit m_to  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst(rst),
    .i_RA1D(RA1D), .i_RA2D(RA2D), .i_RA1E(RA1E), .i_RA2E(RA2E),
    .i_WA3E(WA3E), .i_RegWriteE(RegWriteE), .i_MemtoRegE(MemtoRegE),
    .i_WA3M(WA3M), .i_RegWriteM(RegWriteM), .i_MemtoRegM(MemtoRegM),
    .i_MemWriteM(MemWriteM), .i_PCSrcM(PCSrcM),
    .i_WA3W(WA3W), .i_RegWriteW(RegWriteW), .i_mem_ack(mem_ack),
    .o_StallF(StallF), .o_StallD(StallD), .o_StallE(StallE), .o_StallM(StallM),
    .o_FlushD(FlushD), .o_FlushE(FlushE),
    .o_ForwardAE(FwdA), .o_ForwardBE(FwdB),
    .o_mem_req(mem_req), .o_state(state), .o_timeout(timeout)
  );

  assign outv = {StallF, StallD, StallE, StallM, FlushD, FlushE, FwdA, FwdB,
                 mem_req, state, timeout};

  function automatic logic [1:0] fwd(input logic [3:0] ra);
`ifdef HAZ_FWD_EN
    if (RegWriteM && WA3M == ra) return 2'b10;
    if (RegWriteW && WA3W == ra) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic bit hazard_d();
    bit me, mm;
    me = (WA3E == RA1D) || (WA3E == RA2D);
    mm = (WA3M == RA1D) || (WA3M == RA2D);
`ifdef HAZ_FWD_EN
    return MemtoRegE && RegWriteE && me;
`else
    return (RegWriteE && me) || (RegWriteM && mm);
`endif
  endfunction

  function automatic logic [13:0] model_out();
    bit sF = 0, sD = 0, sE = 0, sM = 0, fD = 0, fE = 0, mreq;
    logic [1:0] fa = 2'b00, fb = 2'b00;
    mreq = (m_st != 2) && (MemtoRegM || MemWriteM);
    if (!rst) begin
      if ((m_st == 1 || (m_st == 0 && mreq)) && !mem_ack) begin
        sF = 1; sD = 1; sE = 1; sM = 1;
      end else if (m_st == 2) fE = 1;
      else if (PCSrcM) begin fD = 1; fE = 1; end
      else if (m_st == 0 && hazard_d()) begin sF = 1; sD = 1; fE = 1; end
      fa = fwd(RA1E);
      fb = fwd(RA2E);
    end
    return {sF, sD, sE, sM, fD, fE, fa, fb, mreq, 2'(m_st), m_to};
  endfunction

  task automatic model_advance();
    bit mreq;
    mreq = (m_st != 2) && (MemtoRegM || MemWriteM);
    if (rst) begin
      m_st = 0; m_cnt = 0; m_to = 0;
    end else if (m_st == 0) begin
      if (mreq && !mem_ack) begin m_st = 1; m_cnt = 0; end
      else if (PCSrcM) m_st = 2;
    end else if (m_st == 1) begin
      if (mem_ack) m_st = PCSrcM ? 2 : 0;
      else begin
        m_cnt++;
        if (m_cnt >= WMAX) begin m_to = 1; m_st = 0; end
      end
    end else m_st = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic clear_inputs();
    {RA1D, RA2D, RA1E, RA2E} = {4'd1, 4'd2, 4'd6, 4'd7};
    {WA3E, WA3M, WA3W} = {4'd9, 4'd10, 4'd11};
    {RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, MemWriteM, PCSrcM, RegWriteW} = 7'b0;
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    RegWriteE = 1; MemtoRegE = 1; WA3E = 4'd1; PCSrcM = 1;
    RegWriteM = 1; WA3M = 4'd6;
    #2;
    n_checks++;
    if (outv !== 14'b0) begin
      n_err++; $display("FAIL reset_hold got %h want %h", outv, 14'b0);
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    #2;
    n_checks++;
    if (outv !== 14'b0) begin
      n_err++; $display("FAIL reset_exit got %h want %h", outv, 14'b0);
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    RegWriteE = 1; MemtoRegE = 1; WA3E = 4'd3; RA1D = 4'd3;
    #2;
    exp = model_out();
    n_checks++;
    if (outv !== exp || {StallF, StallD, FlushE} !== 3'b111) begin
      n_err++; $display("FAIL load_use_stall got %h want %h", outv, exp);
    end
    tick();
    clear_inputs();
    RA1D = 4'd3; WA3M = 4'd3; RegWriteM = 1; MemtoRegM = 1; mem_ack = 1;
    #2;
    exp = model_out();
    n_checks++;
    if (outv !== exp) begin
      n_err++; $display("FAIL load_in_m got %h want %h", outv, exp);
    end
    tick();
    clear_inputs();
    RA1E = 4'd3; WA3W = 4'd3; RegWriteW = 1;
    #2;
    exp = model_out();
    n_checks++;
`ifdef HAZ_FWD_EN
    if (outv !== exp || FwdA !== 2'b01) begin
`else
    if (outv !== exp || FwdA !== 2'b00) begin
`endif
      n_err++; $display("FAIL load_fwd_w got %h want %h", outv, exp);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    MemtoRegM = 1;
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i >= 3);
      if (i == 4) MemtoRegM = 0;
      #2;
      exp = model_out();
      n_checks++;
      if (outv !== exp
          || (i >= 1 && i <= 3 && state !== 2'b01)
          || (i == 4 && state !== 2'b00)
          || {StallF, StallD, StallE, StallM} !== ((i < 3) ? 4'hF : 4'h0)) begin
        n_err++; $display("FAIL mem_wait c%0d got %h want %h", i, outv, exp);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    PCSrcM = 1;
    RegWriteE = 1; MemtoRegE = 1; WA3E = 4'd1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) clear_inputs();
      #2;
      exp = model_out();
      n_checks++;
      if (outv !== exp
          || (i == 0 && {FlushD, FlushE, StallF, StallD} !== 4'b1100)
          || (i == 1 && {state, FlushD, FlushE} !== 4'b1001)
          || (i == 2 && state !== 2'b00)) begin
        n_err++; $display("FAIL branch c%0d got %h want %h", i, outv, exp);
      end
      tick();
    end
    clear_inputs();
    MemWriteM = 1; PCSrcM = 1;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 2);
      if (i == 3) begin MemWriteM = 0; PCSrcM = 0; end
      #2;
      exp = model_out();
      n_checks++;
      if (outv !== exp
          || (i < 2 && {FlushD, FlushE, StallM} !== 3'b001)
          || (i == 2 && {FlushD, FlushE, StallM} !== 3'b110)
          || (i == 3 && state !== 2'b10)) begin
        n_err++; $display("FAIL branch_in_wait c%0d got %h want %h", i, outv, exp);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    clear_inputs();
    MemtoRegM = 1;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) MemtoRegM = 0;
      #2;
      exp = model_out();
      n_checks++;
      if (outv !== exp
          || (i >= 1 && i <= 4 && state !== 2'b01)
          || (i >= 5 && {state, timeout} !== 3'b001)) begin
        n_err++; $display("FAIL timeout c%0d got %h want %h", i, outv, exp);
      end
      tick();
    end
    rst = 1; tick(); rst = 0;
    #2;
    n_checks++;
    if (timeout !== 1'b0) begin
      n_err++; $display("FAIL timeout_clear got %b want 0", timeout);
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    RegWriteM = 1; RegWriteW = 1; WA3M = 4'd5; WA3W = 4'd5; RA2E = 4'd5; RA2D = 4'd5;
    #2;
    exp = model_out();
    n_checks++;
`ifdef HAZ_FWD_EN
    if (outv !== exp || FwdB !== 2'b10 || StallF !== 1'b0) begin
`else
    if (outv !== exp || FwdB !== 2'b00 || {StallF, StallD, FlushE} !== 3'b111) begin
`endif
      n_err++; $display("FAIL forward_mw got %h want %h", outv, exp);
    end
    tick();
  endtask

  task automatic test_reset_midwait();
    clear_inputs();
    MemtoRegM = 1;
    for (int i = 0; i < 10; i++) begin
      rst = (i == 3);
      #2;
      exp = model_out();
      n_checks++;
      if (outv !== exp
          || (i == 3 && {StallF, StallD, StallE, StallM} !== 4'h0)
          || (i == 4 && state !== 2'b00)) begin
        n_err++; $display("FAIL reset_midwait c%0d got %h want %h", i, outv, exp);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
      RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
      WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
      WA3W = 4'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegM = ($urandom_range(0, 99) < 25);
      MemWriteM = ($urandom_range(0, 99) < 10);
      PCSrcM    = ($urandom_range(0, 99) < 15);
      mem_ack   = ($urandom_range(0, 99) < 30);
      rst       = ($urandom_range(0, 99) < 3);
      #2;
      exp = model_out();
      n_checks++;
      if (outv !== exp) begin
        n_err++; $display("FAIL random c%0d got %h want %h", i, outv, exp);
      end
      tick();
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch();
    test_timeout();
    test_forward();
    test_reset_midwait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum memory-wait cycles before timeout, range 1..255.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_RA1D, i_RA2D  input  4 each  decode-stage source register addresses.
REQ-005 i_RA1E, i_RA2E  input  4 each  execute-stage source register addresses.
REQ-006 i_WA3E, i_RegWriteE, i_MemtoRegE  input  4/1/1  execute-stage destination, write enable, load flag.
REQ-007 i_WA3M, i_RegWriteM, i_MemtoRegM, i_MemWriteM, i_PCSrcM  input  4/1/1/1/1  memory-stage fields from the EXE/MEM register.
REQ-008 i_WA3W, i_RegWriteW  input  4/1  writeback-stage destination and write enable.
REQ-009 i_mem_ack  input  1  data memory completes the current access this cycle.
REQ-010 o_StallF, o_StallD, o_StallE, o_StallM  output  1 each  hold the fetch/decode/execute/EXE-MEM stage registers.
REQ-011 o_FlushD, o_FlushE  output  1 each  load a bubble into the decode/execute stage registers.
REQ-012 o_ForwardAE, o_ForwardBE  output  2 each  operand select: 00 regfile, 01 writeback result, 10 memory-stage ALU result.
REQ-013 o_mem_req  output  1  memory access request.
REQ-014 o_state  output  2  current FSM state.
REQ-015 o_timeout  output  1  sticky memory-timeout flag.

Function
REQ-016 FSM states SHALL be RUN=00, MEMWAIT=01, RECOVER=10; encoding 11 SHALL never be entered and SHALL return to RUN.
REQ-017 o_mem_req SHALL equal (i_MemtoRegM | i_MemWriteM) in RUN or MEMWAIT; it SHALL be 0 in RECOVER.
REQ-018 RUN -> MEMWAIT when o_mem_req=1 and i_mem_ack=0; if i_mem_ack=1 in the same cycle, the FSM SHALL stay in RUN with no stall.
REQ-019 In MEMWAIT, o_StallF/D/E/M SHALL all be 1 and both flushes SHALL be 0; the 8-bit wait counter SHALL increment each cycle from 0.
REQ-020 MEMWAIT -> RUN on i_mem_ack=1; the stall SHALL drop in that same cycle and the counter SHALL clear.
REQ-021 MEMWAIT -> RUN when the counter reaches WAIT_MAX with no ack; o_timeout SHALL set and stay 1 until reset.
REQ-022 In RUN with i_PCSrcM=1 (and no memory wait), o_FlushD and o_FlushE SHALL be 1 that cycle, then RUN -> RECOVER.
REQ-023 RECOVER SHALL last exactly one cycle: o_FlushE=1, no load-use stall evaluated; then -> RUN.
REQ-024 A pending memory wait SHALL take priority over i_PCSrcM; a branch asserted during MEMWAIT SHALL be honoured on the ack cycle.
REQ-025 Load-use: in RUN, i_MemtoRegE & i_RegWriteE & (i_WA3E==i_RA1D | i_WA3E==i_RA2D) SHALL assert o_StallF, o_StallD, o_FlushE for one cycle.
REQ-026 Branch flush SHALL take priority over a load-use stall in the same cycle (stall suppressed).
REQ-027 Forwarding, per operand: 10 if i_RegWriteM & i_WA3M==RAxE; else 01 if i_RegWriteW & i_WA3W==RAxE; else 00 (memory stage wins).
REQ-028 All stall/flush/forward outputs SHALL be combinational from inputs and registered state; o_state, the counter, and o_timeout SHALL be registered.

Reset
REQ-029 While rst=1 at a clock edge: state=RUN, counter=0, o_timeout=0.
REQ-030 During and after reset, all stall and flush outputs SHALL be 0, forwards 00, o_mem_req follows REQ-017.
REQ-031 Reset asserted in MEMWAIT or RECOVER SHALL abandon the operation with no residual stall or flush on the next cycle.

Configuration
REQ-032 Macro HAZ_FWD_EN defined: forwarding per REQ-027 and the load-use stall per REQ-025.
REQ-033 HAZ_FWD_EN undefined: o_ForwardAE/BE SHALL be 00; in RUN, any i_RA1D/i_RA2D match to i_WA3E (i_RegWriteE) or i_WA3M (i_RegWriteM) SHALL assert o_StallF, o_StallD, o_FlushE; REQ-025 is removed.

Verification
REQ-034 Load to R3 in E with i_RA1D=3 -> one cycle of StallF=StallD=FlushE=1, then ForwardAE=01 when the load reaches W.
REQ-035 i_MemtoRegM=1, i_mem_ack low 3 cycles -> o_state=01 for 3 cycles, all four stalls 1, release on the ack cycle.
REQ-036 i_PCSrcM=1 in RUN -> FlushD=FlushE=1, next cycle o_state=10 with FlushE=1, then RUN.
REQ-037 WAIT_MAX=4, no ack -> after 4 MEMWAIT cycles state=RUN and o_timeout=1 until rst.
REQ-038 i_RegWriteM=i_RegWriteW=1, i_WA3M=i_WA3W=i_RA2E=5 -> ForwardBE=10; without HAZ_FWD_EN the same hazard at decode -> stall.
REQ-039 rst=1 mid-MEMWAIT -> next cycle o_state=00, no stalls, counter 0.
